// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes (funct3 encoding),
// FSM state type and the legality / alignment helpers used at acceptance.
package load_store_unit_pkg;

  // Width codes, identical to the decoder's funct3 field.
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } lsu_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic lsu_legal(input logic is_store, input logic [2:0] rw_type);
    case (rw_type)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] rw_type, input logic [1:0] addr_lo);
    case (rw_type)
      LSU_H, LSU_HU: return addr_lo[0];
      LSU_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Interface bundling the pipeline request/response handshake and the
// data-memory bus of the load/store unit.
//   master : the load/store unit itself (masters the data bus, answers requests)
//   slave  : the surrounding pipeline and memory model
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  // Pipeline request
  logic              req_valid;
  logic              req_ready;
  logic              mem_rw;
  logic [2:0]        rw_type;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  // Pipeline response
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              resp_illegal;
  logic              resp_buserr;
  // Data-memory bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    input  req_valid, mem_rw, rw_type, addr, wdata, resp_ready, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal, resp_buserr,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport slave (
    output req_valid, mem_rw, rw_type, addr, wdata, resp_ready, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal, resp_buserr,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic of the load/store unit.
//   Store side: replicates store data onto the lanes and builds write strobes
//               (strobes are zero for loads).
//   Load side : picks the byte/half at addr_lo_i out of the bus word and
//               sign- or zero-extends it according to rw_type_i.
// Ports: is_store_i, rw_type_i, addr_lo_i, wdata_i, rdata_i in;
//        wstrb_o, wdata_o, rdata_o out.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  rw_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    if (is_store_i) begin
      case (rw_type_i)
        LSU_B: begin
          wdata_o = {4{wdata_i[7:0]}};
          wstrb_o = 4'b0001 << addr_lo_i;
        end
        LSU_H: begin
          wdata_o = {2{wdata_i[15:0]}};
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        LSU_W: begin
          wdata_o = wdata_i;
          wstrb_o = 4'b1111;
        end
        default: begin
          wdata_o = 32'h0;
          wstrb_o = 4'b0000;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (rw_type_i)
      LSU_B:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  rdata_o = {24'h0, byte_sel};
      LSU_H:   rdata_o = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  rdata_o = {16'h0, half_sel};
      LSU_W:   rdata_o = rdata_i;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time from the pipeline, checks
// legality/alignment, runs a single data-bus transaction with optional
// timeout, and returns extended load data or a fault status.
// Ports: clk, rst_n (synchronous, active-low); lsu_if (master modport) carries
// the request/response handshake and the data-memory bus.
// Flow: IDLE -accept-> BUS -ack/timeout-> (bus_req drops) -> RESP -resp_ready-> IDLE.
// Faulting ops skip BUS and go straight to RESP.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  load_store_unit_if.master      lsu_if
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_e        state_q, state_d;
  logic [2:0]        rw_type_q, rw_type_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;
  logic              buserr_q, buserr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic        in_idle;
  logic [2:0]  align_type;
  logic [1:0]  align_lo;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        req_illegal;
  logic        req_misaligned;
  logic [CntW-1:0] cnt_inc;

  // One aligner serves both directions: live request fields while idle
  // (store steering), latched fields afterwards (load extraction).
  assign in_idle    = (state_q == StIdle);
  assign align_type = in_idle ? lsu_if.rw_type : rw_type_q;
  assign align_lo   = in_idle ? lsu_if.addr[1:0] : addr_lo_q;

  lsu_lane_align u_lane_align (
    .is_store_i (lsu_if.mem_rw),
    .rw_type_i  (align_type),
    .addr_lo_i  (align_lo),
    .wdata_i    (lsu_if.wdata),
    .rdata_i    (lsu_if.bus_rdata),
    .wstrb_o    (align_wstrb),
    .wdata_o    (align_wdata),
    .rdata_o    (align_rdata)
  );

  assign req_illegal    = !lsu_legal(lsu_if.mem_rw, lsu_if.rw_type);
  assign req_misaligned = !req_illegal && lsu_misaligned(lsu_if.rw_type, lsu_if.addr[1:0]);
  assign cnt_inc        = cnt_q + CntW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rw_type_q   <= 3'b000;
      addr_lo_q   <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      buserr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rw_type_q   <= rw_type_d;
      addr_lo_q   <= addr_lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      ill_q       <= ill_d;
      buserr_q    <= buserr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rw_type_d   = rw_type_q;
    addr_lo_d   = addr_lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    ill_d       = ill_q;
    buserr_d    = buserr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (lsu_if.req_valid) begin
          rw_type_d = lsu_if.rw_type;
          addr_lo_d = lsu_if.addr[1:0];
          rdata_d   = 32'h0;
          if (req_illegal || req_misaligned) begin
            ill_d   = req_illegal;
            mis_d   = req_misaligned;
            state_d = StResp;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = lsu_if.mem_rw;
            bus_addr_d  = {lsu_if.addr[ADDR_W-1:2], 2'b00};
            bus_wstrb_d = align_wstrb;
            bus_wdata_d = align_wdata;
            cnt_d       = '0;
            state_d     = StBus;
          end
        end
      end
      StBus: begin
        if (!bus_req_q) begin
          // bus_req already dropped on the previous edge; hand over the result.
          state_d = StResp;
        end else if (lsu_if.bus_ack) begin
          rdata_d   = bus_we_q ? 32'h0 : align_rdata;
          bus_req_d = 1'b0;
          cnt_d     = '0;
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          rdata_d   = 32'h0;
          buserr_d  = 1'b1;
          bus_req_d = 1'b0;
          cnt_d     = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_inc;
        end
      end
      StResp: begin
        if (lsu_if.resp_ready) begin
          rdata_d  = 32'h0;
          mis_d    = 1'b0;
          ill_d    = 1'b0;
          buserr_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    lsu_if.req_ready       = (state_q == StIdle);
    lsu_if.resp_valid      = (state_q == StResp);
    lsu_if.resp_rdata      = rdata_q;
    lsu_if.resp_misaligned = mis_q;
    lsu_if.resp_illegal    = ill_q;
    lsu_if.resp_buserr     = buserr_q;
    lsu_if.bus_req         = bus_req_q;
    lsu_if.bus_we          = bus_we_q;
    lsu_if.bus_addr        = bus_addr_q;
    lsu_if.bus_wstrb       = bus_wstrb_q;
    lsu_if.bus_wdata       = bus_wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  load_store_unit_if #(.ADDR_W(32)) lsu_if ();

  load_store_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lsu_if (lsu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d);
    lsu_if.req_valid = 1'b1;
    lsu_if.mem_rw    = rw;
    lsu_if.rw_type   = t;
    lsu_if.addr      = a;
    lsu_if.wdata     = d;
    tick();
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++; if (lsu_if.req_ready !== 1'b1) begin bad++;
      $display("FAIL reset_req_ready got %b want 1", lsu_if.req_ready); end
    total++; if (lsu_if.resp_valid !== 1'b0) begin bad++;
      $display("FAIL reset_resp_valid got %b want 0", lsu_if.resp_valid); end
    total++; if (lsu_if.bus_req !== 1'b0) begin bad++;
      $display("FAIL reset_bus_req got %b want 0", lsu_if.bus_req); end
    total++; if ({lsu_if.bus_we, lsu_if.bus_wstrb} !== 5'b0) begin bad++;
      $display("FAIL reset_we_wstrb got %b want 00000", {lsu_if.bus_we, lsu_if.bus_wstrb}); end
    total++; if (lsu_if.bus_addr !== 32'h0 || lsu_if.bus_wdata !== 32'h0) begin bad++;
      $display("FAIL reset_bus_addr_wdata got %h/%h want 0/0", lsu_if.bus_addr,
               lsu_if.bus_wdata); end
    total++; if (lsu_if.resp_rdata !== 32'h0) begin bad++;
      $display("FAIL reset_resp_rdata got %h want 0", lsu_if.resp_rdata); end
    total++; if ({lsu_if.resp_misaligned, lsu_if.resp_illegal, lsu_if.resp_buserr} !== 3'b0)
      begin bad++;
      $display("FAIL reset_flags got %b want 000", {lsu_if.resp_misaligned,
               lsu_if.resp_illegal, lsu_if.resp_buserr}); end
  endtask

  task automatic test_sw();
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    total++; if (lsu_if.bus_req !== 1'b1 || lsu_if.req_ready !== 1'b0) begin bad++;
      $display("FAIL sw_bus_req got req=%b ready=%b want 1/0", lsu_if.bus_req,
               lsu_if.req_ready); end
    total++; if (lsu_if.bus_addr !== 32'h100 || lsu_if.bus_we !== 1'b1) begin bad++;
      $display("FAIL sw_addr got %h we=%b want 00000100 we=1", lsu_if.bus_addr,
               lsu_if.bus_we); end
    total++; if (lsu_if.bus_wstrb !== 4'b1111 || lsu_if.bus_wdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL sw_lanes got %b/%h want 1111/deadbeef", lsu_if.bus_wstrb,
               lsu_if.bus_wdata); end
    lsu_if.bus_ack = 1'b1;
    tick();
    lsu_if.bus_ack = 1'b0;
    total++; if (lsu_if.bus_req !== 1'b0 || lsu_if.resp_valid !== 1'b0) begin bad++;
      $display("FAIL sw_after_ack got req=%b valid=%b want 0/0", lsu_if.bus_req,
               lsu_if.resp_valid); end
    tick();
    total++; if (lsu_if.resp_valid !== 1'b1 || lsu_if.resp_rdata !== 32'h0) begin bad++;
      $display("FAIL sw_resp got valid=%b rdata=%h want 1/0", lsu_if.resp_valid,
               lsu_if.resp_rdata); end
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
    total++; if (lsu_if.resp_valid !== 1'b0 || lsu_if.req_ready !== 1'b1) begin bad++;
      $display("FAIL sw_release got valid=%b ready=%b want 0/1", lsu_if.resp_valid,
               lsu_if.req_ready); end
  endtask

  task automatic test_sb();
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
    total++; if (lsu_if.bus_wstrb !== 4'b1000 || lsu_if.bus_wdata !== 32'hA5A5A5A5) begin bad++;
      $display("FAIL sb_lanes got %b/%h want 1000/a5a5a5a5", lsu_if.bus_wstrb,
               lsu_if.bus_wdata); end
    total++; if (lsu_if.bus_addr !== 32'h100) begin bad++;
      $display("FAIL sb_addr got %h want 00000100", lsu_if.bus_addr); end
    lsu_if.bus_ack = 1'b1;
    tick();
    lsu_if.bus_ack = 1'b0;
    tick();
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
  endtask

  // Load with three wait cycles; bus word is only valid alongside bus_ack.
  task automatic test_load(input string name, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
    issue(1'b0, t, a, 32'hFFFFFFFF);
    total++; if (lsu_if.bus_we !== 1'b0 || lsu_if.bus_wstrb !== 4'b0000) begin bad++;
      $display("FAIL %s_we_strb got %b/%b want 0/0000", name, lsu_if.bus_we,
               lsu_if.bus_wstrb); end
    for (int i = 0; i < 3; i++) begin
      lsu_if.bus_rdata = 32'h5A5A5A5A;
      tick();
    end
    total++; if (lsu_if.bus_req !== 1'b1 || lsu_if.bus_addr !== {a[31:2], 2'b00}) begin bad++;
      $display("FAIL %s_wait got req=%b addr=%h want 1/%h", name, lsu_if.bus_req,
               lsu_if.bus_addr, {a[31:2], 2'b00}); end
    lsu_if.bus_ack   = 1'b1;
    lsu_if.bus_rdata = word;
    tick();
    lsu_if.bus_ack   = 1'b0;
    lsu_if.bus_rdata = 32'h0;
    tick();
    total++; if (lsu_if.resp_valid !== 1'b1 || lsu_if.resp_rdata !== exp) begin bad++;
      $display("FAIL %s_rdata got valid=%b rdata=%h want 1/%h", name, lsu_if.resp_valid,
               lsu_if.resp_rdata, exp); end
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
  endtask

  task automatic test_fault(input string name, input logic rw, input logic [2:0] t,
                            input logic [31:0] a, input logic exp_mis, input logic exp_ill);
    issue(rw, t, a, 32'h12345678);
    total++; if (lsu_if.bus_req !== 1'b0 || lsu_if.resp_valid !== 1'b1) begin bad++;
      $display("FAIL %s_path got bus_req=%b valid=%b want 0/1", name, lsu_if.bus_req,
               lsu_if.resp_valid); end
    total++; if (lsu_if.resp_misaligned !== exp_mis || lsu_if.resp_illegal !== exp_ill ||
                 lsu_if.resp_rdata !== 32'h0) begin bad++;
      $display("FAIL %s_flags got mis=%b ill=%b rdata=%h want %b/%b/0", name,
               lsu_if.resp_misaligned, lsu_if.resp_illegal, lsu_if.resp_rdata, exp_mis,
               exp_ill); end
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    while (lsu_if.bus_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n != 16) begin bad++;
      $display("FAIL timeout_cycles got %0d want 16", n); end
    tick();
    total++; if (lsu_if.resp_valid !== 1'b1 || lsu_if.resp_buserr !== 1'b1 ||
                 lsu_if.resp_rdata !== 32'h0) begin bad++;
      $display("FAIL timeout_resp got valid=%b buserr=%b rdata=%h want 1/1/0",
               lsu_if.resp_valid, lsu_if.resp_buserr, lsu_if.resp_rdata); end
    // Hold the response while a new request waits; neither may move.
    lsu_if.req_valid = 1'b1;
    lsu_if.mem_rw    = 1'b1;
    lsu_if.rw_type   = 3'b010;
    lsu_if.addr      = 32'h400;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (lsu_if.resp_valid !== 1'b1 || lsu_if.resp_buserr !== 1'b1 ||
                   lsu_if.req_ready !== 1'b0 || lsu_if.bus_req !== 1'b0) begin bad++;
        $display("FAIL timeout_hold%0d got valid=%b buserr=%b ready=%b bus_req=%b want 1/1/0/0",
                 i, lsu_if.resp_valid, lsu_if.resp_buserr, lsu_if.req_ready, lsu_if.bus_req);
      end
    end
    lsu_if.req_valid  = 1'b0;
    lsu_if.resp_ready = 1'b1;
    tick();
    lsu_if.resp_ready = 1'b0;
    total++; if (lsu_if.resp_buserr !== 1'b0 || lsu_if.req_ready !== 1'b1) begin bad++;
      $display("FAIL timeout_clear got buserr=%b ready=%b want 0/1", lsu_if.resp_buserr,
               lsu_if.req_ready); end
  endtask

  task automatic test_stray_ack();
    lsu_if.bus_ack = 1'b1;
    tick();
    tick();
    lsu_if.bus_ack = 1'b0;
    total++; if (lsu_if.resp_valid !== 1'b0 || lsu_if.bus_req !== 1'b0) begin bad++;
      $display("FAIL idle_ack got valid=%b bus_req=%b want 0/0", lsu_if.resp_valid,
               lsu_if.bus_req); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    total++; if (lsu_if.bus_req !== 1'b0 || lsu_if.req_ready !== 1'b1 ||
                 lsu_if.resp_valid !== 1'b0) begin bad++;
      $display("FAIL midreset got bus_req=%b ready=%b valid=%b want 0/1/0", lsu_if.bus_req,
               lsu_if.req_ready, lsu_if.resp_valid); end
    rst_n = 1'b1;
    lsu_if.bus_ack   = 1'b1;
    lsu_if.bus_rdata = 32'hCAFEF00D;
    tick();
    lsu_if.bus_ack = 1'b0;
    tick();
    tick();
    total++; if (lsu_if.resp_valid !== 1'b0 || lsu_if.bus_req !== 1'b0) begin bad++;
      $display("FAIL late_ack got valid=%b bus_req=%b want 0/0", lsu_if.resp_valid,
               lsu_if.bus_req); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    lsu_if.req_valid  = 1'b0;
    lsu_if.mem_rw     = 1'b0;
    lsu_if.rw_type    = 3'b000;
    lsu_if.addr       = 32'h0;
    lsu_if.wdata      = 32'h0;
    lsu_if.resp_ready = 1'b0;
    lsu_if.bus_ack    = 1'b0;
    lsu_if.bus_rdata  = 32'h0;

    test_reset();
    test_sw();
    test_sb();
    test_load("lb",  3'b000, 32'h102, 32'h1280FF00, 32'hFFFFFF80);
    test_load("lbu", 3'b100, 32'h102, 32'h1280FF00, 32'h00000080);
    test_load("lhu", 3'b101, 32'h102, 32'h1280FF00, 32'h00001280);
    test_load("lh",  3'b001, 32'h100, 32'h1280FF00, 32'hFFFFFF00);
    test_load("lw",  3'b010, 32'h104, 32'h89ABCDEF, 32'h89ABCDEF);
    test_fault("lw_mis",  1'b0, 3'b010, 32'h101, 1'b1, 1'b0);
    test_fault("sbu_ill", 1'b1, 3'b100, 32'h100, 1'b0, 1'b1);
    test_fault("shu_ill", 1'b1, 3'b101, 32'h101, 1'b0, 1'b1);
    test_fault("l011",    1'b0, 3'b011, 32'h100, 1'b0, 1'b1);
    test_timeout();
    test_stray_ack();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumes the decoder's MemRW and RWType, together with the ALU address and rs2 data, for every load or store instruction.
- Runs the data-memory bus transaction: byte-lane steering, write strobes, wait states, load extraction and sign/zero extension.
- Returns a result or error to the writeback path. The pipeline stalls while req_ready is low.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 16, cycles in BUS without bus_ack before a bus error is reported; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  memory op presented
- req_ready  out  1  unit can accept an op
- mem_rw  in  1  1=store, 0=load (decoder MemRW)
- rw_type  in  3  funct3 width code (decoder RWType)
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2)
- resp_valid  out  1  result/status valid
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_misaligned  out  1  alignment fault
- resp_illegal  out  1  unsupported rw_type
- resp_buserr  out  1  bus timeout
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  word-aligned address, addr[1:0]=00
- bus_wstrb  out  4  byte-lane write strobes
- bus_wdata  out  32  lane-steered store data
- bus_ack  in  1  bus completes; bus_rdata valid same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset state (rst_n low at a rising edge): state=IDLE, req_ready=1, resp_valid=0, resp_* flags=0, resp_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, timeout counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid at the clock edge; latch mem_rw, rw_type, addr[1:0], wdata.
  - Legality check at acceptance:
    - Illegal rw_type: loads allow 000/001/010/100/101; stores allow 000/001/010. Anything else sets resp_illegal.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0, sets resp_misaligned.
    - Illegal takes priority over misaligned.
  - Any fault: go to RESP with rdata=0; bus_req never asserts.
  - Legal op: go to BUS. bus_req=1 and bus_* are registered from the same edge.
- BUS:
  - req_ready=0. bus_* stay stable until bus_ack.
  - On bus_ack: capture extended load data (0 for stores), drop bus_req at the next edge, go to RESP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without ack: drop bus_req, set resp_buserr, rdata=0, go to RESP.
  - The counter clears on entry to BUS.
- RESP:
  - resp_valid=1. Outputs are held stable until resp_ready.
  - On resp_ready: clear resp_valid and flags, go to IDLE.
  - The next request can be accepted only from the following cycle (no bypass).
- Latency: accept at edge N gives bus_req high after N. Ack in the first BUS cycle gives resp_valid high after edge N+2.
- Store lane steering:
  - SB: wdata[7:0] replicated on all lanes; wstrb = 0001 << addr[1:0].
  - SH: wdata[15:0] on both halves; wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata as is; wstrb = 1111.
  - For loads, bus_we=0 and wstrb=0000.
- Load extraction:
  - Select the byte/half at addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- bus_ack outside BUS is ignored.
- Reset mid-transaction: state returns to IDLE and bus_req drops at that edge. A late ack after reset is ignored.
- req_valid held during BUS or RESP is not accepted, since req_ready=0.

Decomposition:
- Shared package:
  - width codes LSU_B=000, LSU_H=001, LSU_W=010, LSU_BU=100, LSU_HU=101, matching the decoder's funct3 encoding;
  - the state enum {IDLE, BUS, RESP};
  - a legality function.
- Sub-module lsu_lane_align (combinational): store steering/strobes and load extraction/extension. Verified standalone.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack in 1st BUS cycle -> bus_addr=0x100, wstrb=1111, bus_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, rdata=0.
- SB addr=0x103, wdata=0x000000A5 -> wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
- LB addr=0x102, bus_rdata=0x1280FF00, 3 wait cycles -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x00001280.
- LW addr=0x101 -> no bus_req, resp_misaligned=1, rdata=0. Store with rw_type=100 -> resp_illegal=1, resp_misaligned=0.
- Load, bus_ack never asserts, TIMEOUT_CYCLES=16 -> bus_req drops after 16 BUS cycles, resp_buserr=1. Also hold resp_ready=0 for 5 cycles -> response stable, req_ready=0.
- rst_n low during BUS -> next edge bus_req=0, req_ready=1, resp_valid=0. A later stray bus_ack produces no response.
